serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial N-bit adder that reuses a single one-bit full-adder cell over WIDTH clock cycles, LSB first, with a registered carry. It sits directly downstream of the one-bit full-adder cell and consumes its sum and carry-out every cycle. The surrounding control and datapath accept a parallel operand pair with a start/ready handshake and return a parallel result with a one-cycle done pulse. It trades latency for area relative to a ripple-carry array.

## Interface

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH ≥ 1.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when ready=1.
- a  input  WIDTH  operand A, sampled on the accepting edge.
- b  input  WIDTH  operand B, sampled on the accepting edge.
- cin  input  1  carry-in, sampled on the accepting edge.
- ready  output  1  high in IDLE; decoded combinationally from state.
- busy  output  1  high in SHIFT.
- done  output  1  one-cycle pulse; result is valid.
- sum  output  WIDTH  result register.
- cout  output  1  final carry-out register.

## Operation

- Reset value of every output and register under rst_n=0:
  - state=IDLE, so ready=1, busy=0, done=0.
  - sum=0, cout=0, bit counter=0, carry register=0, operand shift registers=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 loads a and b into shift registers, loads the carry register with cin, clears the counter, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT: each cycle the full-adder cell takes a_sr[0], b_sr[0] and the carry register. On the clock edge:
  - the cell sum shifts into sum at the MSB, with sum shifting right;
  - the carry register takes the cell carry-out;
  - a_sr and b_sr shift right;
  - the counter increments.
  - When the counter reaches WIDTH-1 on that edge, cout takes the cell carry-out and the state moves to DONE.
- DONE: done=1 for exactly one cycle, then the state moves to IDLE unconditionally.
- start while busy or in DONE is ignored: not queued, no effect on the operation in flight.
- sum holds intermediate shifted data during SHIFT. sum and cout are valid from the DONE cycle until the next accepted start.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of a+b+cin.
- Counter width is $clog2(WIDTH) with a minimum of 1.
- WIDTH=1 takes exactly one SHIFT cycle.

## Timing

- Start accepted at edge E0 (start=1, ready=1).
- Edges E1..E_WIDTH process bits 0..WIDTH-1.
- DONE occupies the cycle after E_WIDTH; done is visible there.
- Edge E_WIDTH+1 returns the block to IDLE; ready=1 again.
- Back-to-back throughput: one operation per WIDTH+2 cycles.
- Reset mid-operation: an asynchronous clear to the reset values. No done pulse is produced, and the first post-reset start behaves normally.
- done is never asserted in the same cycle as ready.

## Configuration

- SERIAL_ADDER_OVF_EN defined:
  - adds output port ovf (1 bit, reset 0), registered at the same edge as cout.
  - ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), the two's-complement signed overflow.
  - ovf follows the same validity rules as cout.
- Not defined: the ovf port and its register are absent; behaviour is otherwise identical.

## Structure

- Shared package serial_adder_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - a localparam function for counter width.
- One sub-module, fa_bit: a purely combinational one-bit full adder (a, b, cin → sum, cout). Instantiate it exactly once.
- The top level holds the FSM, counter, shift registers and carry register.

## Test plan

- WIDTH=8, a=0x5A, b=0x3C, cin=0, start at E0 → done=1 in the cycle after E8; sum=0x96, cout=0; ready=1 after E9.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
- a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- start held high continuously with a second operand pair presented while busy → second pair ignored. First result correct; the next acceptance occurs only at E_WIDTH+2.
- rst_n pulsed low after E4 of an operation → all outputs reset immediately, no done pulse. A following 0x01+0x01 yields sum=0x02.
- With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01 → sum=0x80, ovf=1, cout=0; a=0x80, b=0x80 → sum=0x00, ovf=1, cout=1. Repeat the first scenario with WIDTH=1: 1+1 → sum=0, cout=1, done after E1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared types and helpers for the bit-serial adder.
//                - state_e     : FSM encoding (IDLE, SHIFT, DONE)
//                - cnt_width() : bit-counter width, $clog2(WIDTH) floored at 1
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // $clog2(1) is 0, which would give a zero-width counter.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_adder_fa_bit.sv
`default_nettype none
// ============================================================================
//  Module      : fa_bit
//  Description : Purely combinational one-bit full adder.
//  Ports       : a, b, cin -> addend bits and carry-in
//                sum, cout -> sum bit and carry-out
//  Revision    : 1.0 - initial release
// ============================================================================
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial WIDTH-bit adder. One full-adder cell is reused
//                for WIDTH cycles, LSB first, with a registered carry.
//                Start/ready handshake in, one-cycle done pulse out.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                start, a, b, cin    - request and operands (sampled on accept)
//                ready / busy / done - IDLE / SHIFT / DONE state decode
//                sum, cout           - result registers
//                ovf                 - signed overflow (SERIAL_ADDER_OVF_EN)
//  Config      : define SERIAL_ADDER_OVF_EN to add the ovf output.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q,  a_sr_d;
  logic [WIDTH-1:0]   b_sr_q,  b_sr_d;
  logic [WIDTH-1:0]   sum_q,   sum_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q,  cout_d;
  logic               ovf_q,   ovf_d;

  logic               fa_sum;
  logic               fa_cout;
  logic [WIDTH:0]     sum_shift;

  fa_bit u_fa_bit (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; written this way so WIDTH=1 needs no
  // special case for the empty lower slice.
  assign sum_shift = {fa_sum, sum_q} >> 1;

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sum_d   = sum_shift[WIDTH-1:0];
        carry_d = fa_cout;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cout_d  = fa_cout;
          // carry_q is the carry into the MSB during the last bit.
          ovf_d   = carry_q ^ fa_cout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`else
  // Register exists only to keep the datapath uniform; it is not observable.
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder. Drives a WIDTH=8 and a
//                WIDTH=1 instance from shared stimulus and compares both
//                against a transaction-level arithmetic model every cycle.
//  Config      : SERIAL_ADDER_OVF_EN enables the ovf checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       cin;

  logic       ready8, busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       ready1, busy1, done1, cout1, ovf1;
  logic [0:0] sum1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a[0:0]), .b(b[0:0]), .cin(cin),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf1 = 1'b0;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // k[i] < 0 : idle. k[i] = n : n cycles since acceptance (0..W-1 shifting,
  // W = done cycle). Results computed with plain arithmetic at acceptance.
  int         wid[2] = '{8, 1};
  int         k[2]   = '{-1, -1};
  logic [7:0] ps[2]  = '{8'd0, 8'd0};
  logic       pc[2]  = '{1'b0, 1'b0};
  logic       po[2]  = '{1'b0, 1'b0};
  logic [7:0] es[2]  = '{8'd0, 8'd0};
  logic       ec[2]  = '{1'b0, 1'b0};
  logic       eo[2]  = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    int w, mask, xa, xb, full;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        k[i] = -1; es[i] = '0; ec[i] = 1'b0; eo[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (k[i] < 0) begin
          if (start) begin
            w    = wid[i];
            mask = (1 << w) - 1;
            xa   = int'(a) & mask;
            xb   = int'(b) & mask;
            full = xa + xb + int'(cin);
            ps[i] = 8'(full & mask);
            pc[i] = ((full >> w) & 1) == 1;
            // Signed overflow: operands agree in sign, result does not.
            po[i] = (((xa >> (w-1)) & 1) == ((xb >> (w-1)) & 1)) &&
                    (((full >> (w-1)) & 1) != ((xa >> (w-1)) & 1));
            k[i] = 0;
          end
        end else begin
          k[i]++;
          if (k[i] == wid[i]) begin
            es[i] = ps[i]; ec[i] = pc[i]; eo[i] = po[i];
          end else if (k[i] == wid[i] + 1) begin
            k[i] = -1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int  rdy, bsy, dn, s, c, o;
      logic exp_busy;
      rdy = (i == 0) ? int'(ready8) : int'(ready1);
      bsy = (i == 0) ? int'(busy8)  : int'(busy1);
      dn  = (i == 0) ? int'(done8)  : int'(done1);
      s   = (i == 0) ? int'(sum8)   : int'(sum1);
      c   = (i == 0) ? int'(cout8)  : int'(cout1);
      o   = (i == 0) ? int'(ovf8)   : int'(ovf1);
      exp_busy = (k[i] >= 0) && (k[i] < wid[i]);
      chk($sformatf("ready_w%0d", wid[i]), rdy, int'(k[i] < 0));
      chk($sformatf("busy_w%0d", wid[i]),  bsy, int'(exp_busy));
      chk($sformatf("done_w%0d", wid[i]),  dn,  int'(k[i] == wid[i]));
      if (!exp_busy) begin
        chk($sformatf("sum_w%0d", wid[i]),  s, int'(es[i]));
        chk($sformatf("cout_w%0d", wid[i]), c, int'(ec[i]));
`ifdef SERIAL_ADDER_OVF_EN
        chk($sformatf("ovf_w%0d", wid[i]),  o, int'(eo[i]));
`endif
      end
    end
  end

  // ---------------- directed operation helper ----------------
  task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                    output logic [7:0] rs, output logic rc, output logic ro,
                    output int lat8, output int lat1);
    int n;
    n = 0;
    rs = '0; rc = 1'b0; ro = 1'b0;
    @(negedge clk);
    while (!(ready8 && ready1) && n < 30) begin @(negedge clk); n++; end
    if (n >= 30) chk("ready_timeout", 0, 1);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat8 = 0; lat1 = 0; n = 0;
    while (lat8 == 0 && n < 30) begin
      @(negedge clk); n++;
      if (done1 && lat1 == 0) lat1 = n;
      if (done8) begin lat8 = n; rs = sum8; rc = cout8; ro = ovf8; end
    end
    if (lat8 == 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rs;
    logic       rc, ro;
    int         l8, l1, n;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sum",   int'(sum8),   0);
    chk("rst_ready", int'(ready8), 1);
    chk("rst_busy",  int'(busy8),  0);
    rst_n = 1'b1;

    op(8'h5A, 8'h3C, 1'b0, rs, rc, ro, l8, l1);
    chk("d1_sum", int'(rs), 'h96);
    chk("d1_cout", int'(rc), 0);
    chk("d1_lat", l8, 9);
    chk("d1_model", int'(es[0]), 'h96);
    @(negedge clk);
    chk("d1_ready_after", int'(ready8), 1);

    op(8'hFF, 8'h01, 1'b0, rs, rc, ro, l8, l1);
    chk("d2_sum", int'(rs), 'h00);
    chk("d2_cout", int'(rc), 1);

    op(8'hFF, 8'hFF, 1'b1, rs, rc, ro, l8, l1);
    chk("d3_sum", int'(rs), 'hFF);
    chk("d3_cout", int'(rc), 1);

    op(8'h01, 8'h01, 1'b0, rs, rc, ro, l8, l1);
    chk("d4_sum", int'(rs), 'h02);
    chk("w1_lat", l1, 2);
    chk("w1_sum", int'(sum1), 0);
    chk("w1_cout", int'(cout1), 1);

`ifdef SERIAL_ADDER_OVF_EN
    op(8'h7F, 8'h01, 1'b0, rs, rc, ro, l8, l1);
    chk("ovf1_sum", int'(rs), 'h80);
    chk("ovf1_ovf", int'(ro), 1);
    chk("ovf1_cout", int'(rc), 0);
    op(8'h80, 8'h80, 1'b0, rs, rc, ro, l8, l1);
    chk("ovf2_sum", int'(rs), 'h00);
    chk("ovf2_ovf", int'(ro), 1);
    chk("ovf2_cout", int'(rc), 1);
`endif

    // start held high; second pair presented while busy must be ignored
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1 a = 8'hAA; b = 8'h55;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 9)  begin chk("hold_done", int'(done8), 1); chk("hold_sum", int'(sum8), 'h46); end
      if (i == 10) chk("hold_ready", int'(ready8), 1);
      if (i == 11) chk("hold_reaccept", int'(busy8), 1);
    end
    start = 1'b0;
    n = 0;
    while (!done8 && n < 20) begin @(negedge clk); n++; end
    chk("hold_second_sum", int'(sum8), 'hFF);

    // asynchronous reset after E4 of an operation
    op(8'h00, 8'h00, 1'b0, rs, rc, ro, l8, l1);
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum",   int'(sum8),   0);
    chk("arst_busy",  int'(busy8),  0);
    chk("arst_ready", int'(ready8), 1);
    chk("arst_done",  int'(done8),  0);
    @(negedge clk); rst_n = 1'b1;
    op(8'h01, 8'h01, 1'b0, rs, rc, ro, l8, l1);
    chk("post_rst_sum", int'(rs), 'h02);

    // randomized traffic, including start requests while busy
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a     = 8'($urandom);
      b     = 8'($urandom);
      cin   = 1'($urandom);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
